pre_egr_filt_tagger: RTL and testbench
======================================

// Module: pre_egr_filt_tagger
// PURPOSE
// - Registered AXIS stage ahead of the egress filter; builds the filter tuser sideband from the stream itself.
// - Adds per-packet running byte position, sticky poison on oversize or malformed tkeep, and optional broadcast route mask.
// - Full throughput, one pipeline register plus skid; tdata/tid/tdest/tkeep/tlast pass through unchanged.
// PARAMETERS
// - AXIS_BUS_WIDTH     64    tdata width, multiple of 8; NUM_BUS_BYTES = AXIS_BUS_WIDTH/8
// - AXIS_ID_WIDTH      4     tid width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH
// - AXIS_DEST_WIDTH    0     tdest width; port is 1 bit when 0
// - MAX_PACKET_LENGTH  1522  largest legal packet in bytes; PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH+1)
// - ROUTE_BCAST        0     0: route_mask = 0; 1: route_mask = all ones except bit[tid]
// - Derived: MAX_ADDED_OFFSET_CBITS = 6; TUSER_OUT_WIDTH = NUM_AXIS_ID + PACKET_LENGTH_CBITS + 6 + 5
// PORTS
// - aclk            in   1                clock, all logic on rising edge
// - aresetn         in   1                asynchronous reset, active low
// - axis_in_tdata   in   AXIS_BUS_WIDTH   input data
// - axis_in_tid     in   max(ID,1)        source id
// - axis_in_tdest   in   max(DEST,1)      destination
// - axis_in_tkeep   in   NUM_BUS_BYTES    byte enables
// - axis_in_tlast   in   1                end of packet
// - axis_in_tvalid  in   1                input valid
// - axis_in_tready  out  1                input ready, driven straight from a flop
// - axis_out_tdata/tid/tdest/tkeep/tlast  out  as input                 registered copies of the input
// - axis_out_tuser  out  TUSER_OUT_WIDTH  {has_udp_checksum, next_can_have_vsid, added_offset[5:0], cur_pos, next_is_config, parsing_done, poisoned, route_mask}
// - axis_out_tvalid out  1                output valid
// - axis_out_tready in   1                output ready
// BEHAVIOUR
// - Reset (aresetn=0, async): axis_out_tvalid=0, axis_out_tuser=0, all data outputs 0, axis_in_tready=0, skid empty, pos_acc=0, poison_st=0, in_pkt=0.
// - First aclk edge after release: axis_in_tready=1. Next input beat is treated as start of packet.
// - Handshake: a beat is accepted on tvalid&tready. Output holds stable while tvalid & !tready.
// - axis_in_tready = !skid_full. Skid fills only when the output register holds data and is stalled.
// - Latency: 1 cycle input to output when not stalled. Sustains 1 beat/cycle. No beat lost or duplicated.
// - Byte count: cnt = popcount(tkeep), 0..NUM_BUS_BYTES.
// - cur_pos = min(pos_acc + cnt, 2**PACKET_LENGTH_CBITS-1), computed one bit wider before saturation.
// - pos_acc <= cur_pos on each accepted beat. pos_acc <= 0 on an accepted tlast beat.
// - Poison conditions, per beat:
//   - (a) unsaturated pos_acc + cnt > MAX_PACKET_LENGTH
//   - (b) tlast=0 and tkeep != all ones
//   - (c) tlast=1 and tkeep not of the form 0..01..1, or tkeep=0
// - poisoned = poison_st | cond. poison_st <= poisoned on an accepted non-last beat; cleared on an accepted tlast beat.
// - Poison is sticky: it applies to the offending beat and all later beats of the same packet.
// - Constant tuser fields: parsing_done=1, next_is_config=0, added_offset=0, next_can_have_vsid=0, has_udp_checksum=0.
// - route_mask: from that beat's tid per ROUTE_BCAST. Computed per beat, not latched at packet start.
// - Tuser fields are computed at input acceptance and stored alongside the beat in the output register and skid slot.
// - Single-beat packet (tlast on first beat): cur_pos=cnt. Accumulator and poison state clear at the same edge.
// - Reset asserted mid-packet: discard all state. The partial packet is not completed on the output.
// CONFIGURATION
// - PRE_EGR_TAGGER_STATS_EN defined: adds two ports, stat_pkt_count and stat_poison_count (out, 32 bits each).
//   - stat_pkt_count increments on each tlast beat accepted at the output.
//   - stat_poison_count increments when that tlast beat carries poisoned=1.
//   - Both wrap at 2**32 and reset to 0.
// - Macro undefined: the stat ports and counters do not exist. All other behaviour is identical.
// TESTING
// - 64-bit bus, 3-beat packet, tkeep FF,FF,0F, tout_ready=1 -> cur_pos 8,16,20; poisoned=0; tlast on beat 3; 1-cycle latency.
// - 1530-byte packet (191 full beats + tkeep 03) -> poisoned=0 through cur_pos=1520; 1 on the beat reaching 1522+ and all later beats; next packet clean.
// - Non-last beat with tkeep=7F -> poisoned=1 from that beat to tlast. Last beat with tkeep=F0 -> poisoned=1 on that beat only.
// - axis_out_tready toggled 1,0,0,1 during 8-beat stream -> in_tready falls after skid fills; output order and tuser exact; no drop or dup.
// - ROUTE_BCAST=1, tid=3, AXIS_ID_WIDTH=2 -> route_mask=4'b0111. ROUTE_BCAST=0 -> route_mask=0.
// - aresetn pulsed mid-packet at pos 16 -> out_tvalid=0 asynchronously; next packet tkeep FF -> cur_pos=8. With STATS_EN, counters read 0.

Source files
------------

// File: rtl/pre_egr_filt_tagger_if.sv
// AXI-Stream bundle used on both sides of the pre-egress filter tagger.
// The slave modport omits tuser: the tagger builds its own sideband and
// never looks at an upstream one.
interface pre_egr_filt_tagger_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0]   tdata;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tid, tdest, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/pre_egr_filt_tagger.sv
// Registered AXIS stage ahead of the egress filter. Builds the filter tuser
// sideband (running byte position, sticky poison, route mask) from the stream
// and passes data/id/dest/keep/last through unchanged. One output register
// plus a one-entry skid slot keep full throughput with a flop-driven tready.
// Optional macro PRE_EGR_TAGGER_STATS_EN adds packet/poison counters.
module pre_egr_filt_tagger #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int AXIS_DEST_WIDTH   = 0,
  parameter int MAX_PACKET_LENGTH = 1522,
  parameter int ROUTE_BCAST       = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  pre_egr_filt_tagger_if.slave  axis_in,
  pre_egr_filt_tagger_if.master axis_out
`ifdef PRE_EGR_TAGGER_STATS_EN
  ,
  output logic [31:0]           stat_pkt_count,
  output logic [31:0]           stat_poison_count
`endif
);

  localparam int NUM_BUS_BYTES       = AXIS_BUS_WIDTH / 8;
  localparam int NUM_AXIS_ID         = 2 ** AXIS_ID_WIDTH;
  localparam int ID_PW               = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1;
  localparam int DEST_PW             = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1;
  localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 1);
  localparam int TUSER_OUT_WIDTH     = NUM_AXIS_ID + PACKET_LENGTH_CBITS + 6 + 5;
  localparam int CNT_W               = $clog2(NUM_BUS_BYTES + 1);
  localparam int PLC                 = PACKET_LENGTH_CBITS;

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0]  data;
    logic [ID_PW-1:0]           id;
    logic [DEST_PW-1:0]         dest;
    logic [NUM_BUS_BYTES-1:0]   keep;
    logic                       last;
    logic [TUSER_OUT_WIDTH-1:0] user;
  } beat_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_BUS_BYTES-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_BUS_BYTES; i++) c = c + CNT_W'(k[i]);
    return c;
  endfunction

  // Clamp the one-bit-wider sum back into the position field.
  function automatic logic [PLC-1:0] sat_pos(input logic [PLC:0] s);
    return s[PLC] ? {PLC{1'b1}} : s[PLC-1:0];
  endfunction

  // True for a non-empty keep of the form 0..01..1.
  function automatic logic keep_contig(input logic [NUM_BUS_BYTES-1:0] k);
    logic [NUM_BUS_BYTES-1:0] kp1;
    kp1 = k + NUM_BUS_BYTES'(1);
    return (k != '0) && ((k & kp1) == '0);
  endfunction

  logic [PLC-1:0]         pos_acc;
  logic                   poison_st;
  logic                   in_rdy;
  logic                   vld_p1;
  logic                   skid_full;
  beat_t                  out_p1;
  beat_t                  skid_p1;

  logic [CNT_W-1:0]       cnt_p0;
  logic [PLC:0]           sum_p0;
  logic [PLC-1:0]         cur_pos_p0;
  logic                   cond_p0;
  logic                   poisoned_p0;
  logic [NUM_AXIS_ID-1:0] route_p0;
  beat_t                  beat_p0;
  logic                   acc_p0;
  logic                   out_free;
  logic                   load_skid;
  logic                   skid_full_nxt;

  // Stage p0: tag the incoming beat and decide where it lands.
  always_comb begin
    cnt_p0      = popcnt(axis_in.tkeep);
    sum_p0      = {1'b0, pos_acc} + (PLC+1)'(cnt_p0);
    cur_pos_p0  = sat_pos(sum_p0);
    cond_p0     = (sum_p0 > (PLC+1)'(MAX_PACKET_LENGTH))
                | (!axis_in.tlast && (axis_in.tkeep != {NUM_BUS_BYTES{1'b1}}))
                | (axis_in.tlast && !keep_contig(axis_in.tkeep));
    poisoned_p0 = poison_st | cond_p0;
    route_p0    = (ROUTE_BCAST != 0) ? ~(NUM_AXIS_ID'(1) << axis_in.tid) : '0;
    beat_p0.data = axis_in.tdata;
    beat_p0.id   = axis_in.tid;
    beat_p0.dest = axis_in.tdest;
    beat_p0.keep = axis_in.tkeep;
    beat_p0.last = axis_in.tlast;
    beat_p0.user = {1'b0, 1'b0, 6'd0, cur_pos_p0, 1'b0, 1'b1, poisoned_p0, route_p0};
    acc_p0        = axis_in.tvalid & in_rdy;
    out_free      = !vld_p1 | axis_out.tready;
    load_skid     = acc_p0 & !out_free;
    skid_full_nxt = skid_full ? !out_free : load_skid;
  end

  // Stage p1: output register, skid occupancy, ready and per-packet state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1    <= 1'b0;
      out_p1    <= '0;
      skid_full <= 1'b0;
      in_rdy    <= 1'b0;
      pos_acc   <= '0;
      poison_st <= 1'b0;
    end else begin
      skid_full <= skid_full_nxt;
      in_rdy    <= !skid_full_nxt;
      if (out_free) begin
        vld_p1 <= skid_full | acc_p0;
        if (skid_full)   out_p1 <= skid_p1;
        else if (acc_p0) out_p1 <= beat_p0;
      end
      if (acc_p0) begin
        pos_acc   <= axis_in.tlast ? '0 : cur_pos_p0;
        poison_st <= axis_in.tlast ? 1'b0 : poisoned_p0;
      end
    end
  end

  // Skid slot payload: only meaningful while skid_full is set.
  always_ff @(posedge aclk) begin
    if (load_skid) skid_p1 <= beat_p0;
  end

  assign axis_in.tready  = in_rdy;
  assign axis_out.tdata  = out_p1.data;
  assign axis_out.tid    = out_p1.id;
  assign axis_out.tdest  = out_p1.dest;
  assign axis_out.tkeep  = out_p1.keep;
  assign axis_out.tlast  = out_p1.last;
  assign axis_out.tuser  = out_p1.user;
  assign axis_out.tvalid = vld_p1;

`ifdef PRE_EGR_TAGGER_STATS_EN
  // Count packets, and poisoned packets, as their last beat leaves the stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_pkt_count    <= '0;
      stat_poison_count <= '0;
    end else if (vld_p1 && axis_out.tready && out_p1.last) begin
      stat_pkt_count <= stat_pkt_count + 32'd1;
      if (out_p1.user[NUM_AXIS_ID]) stat_poison_count <= stat_poison_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pre_egr_filt_tagger.sv
// Directed self-checking bench for pre_egr_filt_tagger: reset, position and
// poison tagging, oversize, malformed keep, stalls, broadcast route mask and
// mid-packet reset. A second instance covers ROUTE_BCAST=1 with 2-bit tid.
module tb_pre_egr_filt_tagger;

  localparam int UW  = 38;  // 16 + 11 + 11
  localparam int UW2 = 26;  // 4 + 11 + 11

  logic clk;
  logic aresetn;
  int   tests;
  int   fails;

  pre_egr_filt_tagger_if #(.DATA_W(64), .ID_W(4), .DEST_W(1), .USER_W(UW))  in_if ();
  pre_egr_filt_tagger_if #(.DATA_W(64), .ID_W(4), .DEST_W(1), .USER_W(UW))  out_if ();
  pre_egr_filt_tagger_if #(.DATA_W(64), .ID_W(2), .DEST_W(1), .USER_W(UW2)) in2_if ();
  pre_egr_filt_tagger_if #(.DATA_W(64), .ID_W(2), .DEST_W(1), .USER_W(UW2)) out2_if ();

`ifdef PRE_EGR_TAGGER_STATS_EN
  logic [31:0] stat_pkt, stat_pois, stat_pkt2, stat_pois2;
`endif

  pre_egr_filt_tagger dut (
    .aclk(clk), .aresetn(aresetn), .axis_in(in_if.slave), .axis_out(out_if.master)
`ifdef PRE_EGR_TAGGER_STATS_EN
    , .stat_pkt_count(stat_pkt), .stat_poison_count(stat_pois)
`endif
  );

  pre_egr_filt_tagger #(.AXIS_ID_WIDTH(2), .ROUTE_BCAST(1)) dut_bc (
    .aclk(clk), .aresetn(aresetn), .axis_in(in2_if.slave), .axis_out(out2_if.master)
`ifdef PRE_EGR_TAGGER_STATS_EN
    , .stat_pkt_count(stat_pkt2), .stat_poison_count(stat_pois2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   d;
    logic [7:0]    k;
    logic          l;
    logic [UW-1:0] u;
  } obs_t;

  obs_t q[$];
  bit   saw_not_ready;

  // Record every beat that transfers on the main output.
  always @(negedge clk) begin
    if (aresetn && out_if.tvalid && out_if.tready)
      q.push_back({out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser});
    if (aresetn && in_if.tvalid && !in_if.tready)
      saw_not_ready = 1'b1;
  end

  // Expected main-instance tuser: route mask is 0 for ROUTE_BCAST=0.
  function automatic logic [UW-1:0] exp_tu(input int pos, input bit pois);
    return {8'd0, 11'(pos), 1'b0, 1'b1, pois, 16'd0};
  endfunction

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
    in_if.tid    = 4'd1;
    in_if.tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_if.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL drive_timeout: tready stayed %0b, required 1", in_if.tready);
    end
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (out_if.tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %0b want 0", out_if.tvalid); end
    tests++; if (out_if.tuser !== '0) begin fails++; $display("FAIL rst_tuser: got %h want 0", out_if.tuser); end
    tests++; if (out_if.tdata !== 64'd0) begin fails++; $display("FAIL rst_tdata: got %h want 0", out_if.tdata); end
    tests++; if (in_if.tready !== 1'b0) begin fails++; $display("FAIL rst_tready: got %0b want 0", in_if.tready); end
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    tests++; if (in_if.tready !== 1'b0) begin fails++; $display("FAIL rel_tready_early: got %0b want 0", in_if.tready); end
    @(posedge clk);
    #1;
    tests++; if (in_if.tready !== 1'b1) begin fails++; $display("FAIL rel_tready: got %0b want 1", in_if.tready); end
  endtask

  task automatic test_basic;
    logic [63:0] dv [3];
    logic [7:0]  kv [3];
    int          pv [3];
    dv[0] = 64'h1111; dv[1] = 64'h2222; dv[2] = 64'h3333;
    kv[0] = 8'hFF;    kv[1] = 8'hFF;    kv[2] = 8'h0F;
    pv[0] = 8;        pv[1] = 16;       pv[2] = 20;
    for (int i = 0; i < 3; i++) begin
      in_if.tdata  = dv[i];
      in_if.tkeep  = kv[i];
      in_if.tlast  = (i == 2);
      in_if.tid    = 4'd2;
      in_if.tvalid = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (out_if.tvalid !== 1'b1 || out_if.tdata !== dv[i] || out_if.tkeep !== kv[i])
        begin fails++; $display("FAIL basic_beat%0d: vld %0b data %h keep %h want 1 %h %h", i, out_if.tvalid, out_if.tdata, kv[i], dv[i], kv[i]); end
      tests++; if (out_if.tuser !== exp_tu(pv[i], 1'b0))
        begin fails++; $display("FAIL basic_tuser%0d: got %h want %h", i, out_if.tuser, exp_tu(pv[i], 1'b0)); end
      tests++; if (out_if.tlast !== (i == 2))
        begin fails++; $display("FAIL basic_tlast%0d: got %0b want %0b", i, out_if.tlast, (i == 2)); end
    end
    in_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (out_if.tvalid !== 1'b0) begin fails++; $display("FAIL basic_idle: tvalid %0b want 0", out_if.tvalid); end
  endtask

  task automatic test_oversize;
    int pos;
    q.delete();
    for (int i = 0; i < 191; i++) drive_beat(64'(i), 8'hFF, 1'b0);
    drive_beat(64'hE0, 8'h03, 1'b1);
    drive_beat(64'hE1, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    tests++; if (q.size() != 193) begin fails++; $display("FAIL over_count: got %0d beats want 193", q.size()); end
    for (int i = 0; i < 193 && i < q.size(); i++) begin
      pos = (i < 191) ? 8 * (i + 1) : ((i == 191) ? 1530 : 8);
      tests++; if (q[i].u !== exp_tu(pos, (i == 190 || i == 191)))
        begin fails++; $display("FAIL over_beat%0d: tuser %h want %h", i, q[i].u, exp_tu(pos, (i == 190 || i == 191))); end
    end
  endtask

  task automatic test_malformed;
    logic [7:0] kv [9];
    logic       lv [9];
    int         pv [9];
    bit         xv [9];
    kv = '{8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'h00, 8'hFF, 8'hFF};
    lv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pv = '{8, 15, 23, 31, 8, 12, 0, 8, 16};
    xv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    q.delete();
    for (int i = 0; i < 9; i++) drive_beat(64'h100 + 64'(i), kv[i], lv[i]);
    repeat (3) @(posedge clk);
    #1;
    tests++; if (q.size() != 9) begin fails++; $display("FAIL mal_count: got %0d want 9", q.size()); end
    for (int i = 0; i < 9 && i < q.size(); i++) begin
      tests++; if (q[i].u !== exp_tu(pv[i], xv[i]) || q[i].k !== kv[i] || q[i].l !== lv[i])
        begin fails++; $display("FAIL mal_beat%0d: tuser %h keep %h last %0b want %h %h %0b", i, q[i].u, q[i].k, q[i].l, exp_tu(pv[i], xv[i]), kv[i], lv[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat;
    pat = 4'b1001;
    q.delete();
    saw_not_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_beat(64'hA0 + 64'(i), 8'hFF, (i == 7));
      end
      begin
        for (int c = 0; c < 24; c++) begin
          out_if.tready = pat[3 - (c % 4)];
          @(posedge clk);
          #1;
        end
        out_if.tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    tests++; if (saw_not_ready !== 1'b1) begin fails++; $display("FAIL stall_ready: in_tready low seen %0b want 1", saw_not_ready); end
    tests++; if (q.size() != 8) begin fails++; $display("FAIL stall_count: got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      tests++; if (q[i].d !== 64'hA0 + 64'(i) || q[i].u !== exp_tu(8 * (i + 1), 1'b0) || q[i].l !== (i == 7))
        begin fails++; $display("FAIL stall_beat%0d: data %h tuser %h want %h %h", i, q[i].d, q[i].u, 64'hA0 + 64'(i), exp_tu(8 * (i + 1), 1'b0)); end
    end
  endtask

  task automatic test_route;
    logic [UW2-1:0] e3, e0;
    e3 = {8'd0, 11'd8, 3'b010, 4'b0111};
    e0 = {8'd0, 11'd8, 3'b010, 4'b1110};
    in2_if.tdata  = 64'h55;
    in2_if.tkeep  = 8'hFF;
    in2_if.tlast  = 1'b1;
    in2_if.tid    = 2'd3;
    in2_if.tvalid = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (out2_if.tvalid !== 1'b1 || out2_if.tuser !== e3)
      begin fails++; $display("FAIL route_tid3: vld %0b tuser %h want 1 %h", out2_if.tvalid, out2_if.tuser, e3); end
    in2_if.tid = 2'd0;
    @(posedge clk);
    #1;
    tests++; if (out2_if.tvalid !== 1'b1 || out2_if.tuser !== e0)
      begin fails++; $display("FAIL route_tid0: vld %0b tuser %h want 1 %h", out2_if.tvalid, out2_if.tuser, e0); end
    in2_if.tvalid = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive_beat(64'h55, 8'hFF, 1'b0);
    drive_beat(64'h66, 8'hFF, 1'b0);
    #1;
    aresetn = 1'b0;
    #1;
    tests++; if (out_if.tvalid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid: got %0b want 0", out_if.tvalid); end
    tests++; if (in_if.tready !== 1'b0 || out_if.tdata !== 64'd0)
      begin fails++; $display("FAIL midrst_state: tready %0b tdata %h want 0 0", in_if.tready, out_if.tdata); end
`ifdef PRE_EGR_TAGGER_STATS_EN
    tests++; if (stat_pkt !== 32'd0 || stat_pois !== 32'd0)
      begin fails++; $display("FAIL midrst_stats: pkt %0d pois %0d want 0 0", stat_pkt, stat_pois); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    drive_beat(64'h77, 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (q.size() != 1) begin fails++; $display("FAIL midrst_count: got %0d want 1", q.size()); end
    if (q.size() >= 1) begin
      tests++; if (q[0].u !== exp_tu(8, 1'b0) || q[0].d !== 64'h77)
        begin fails++; $display("FAIL midrst_beat: tuser %h data %h want %h 77", q[0].u, q[0].d, exp_tu(8, 1'b0)); end
    end
`ifdef PRE_EGR_TAGGER_STATS_EN
    tests++; if (stat_pkt !== 32'd1 || stat_pois !== 32'd0)
      begin fails++; $display("FAIL stats_after: pkt %0d pois %0d want 1 0", stat_pkt, stat_pois); end
`endif
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    aresetn = 1'b0;
    in_if.tdata = '0;  in_if.tid = '0;  in_if.tdest = '0;  in_if.tkeep = '0;
    in_if.tlast = 1'b0; in_if.tuser = '0; in_if.tvalid = 1'b0;
    out_if.tready = 1'b1;
    in2_if.tdata = '0; in2_if.tid = '0; in2_if.tdest = '0; in2_if.tkeep = '0;
    in2_if.tlast = 1'b0; in2_if.tuser = '0; in2_if.tvalid = 1'b0;
    out2_if.tready = 1'b1;
    saw_not_ready = 1'b0;
    test_reset();
    test_basic();
    test_oversize();
    test_malformed();
    test_back_to_back();
    test_route();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
